matmul_input_feeder: RTL and testbench

//  Transmit-side counterpart of the systolic output collector. Buffers up to ROWS input vectors of COLS words each.
//  On start, streams them into the systolic array one lane per column, with lane c skewed by c clk cycles.

---
 rtl/matmul_input_feeder_if.sv | 31 +++
 rtl/matmul_input_feeder.sv | 215 +++++++++++++++++++++
 tb/tb_matmul_input_feeder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_input_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_input_feeder_if
// Description : Load / start / feed bus of the systolic input feeder.
//               master = loader/controller side, slave = feeder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_input_feeder_if #(
    parameter int WORD_SIZE = 16,
    parameter int COLS      = 4
);
    logic                      load_valid;
    logic                      load_ready;
    logic [COLS*WORD_SIZE-1:0] load_data;
    logic                      start;
    logic                      busy;
    logic [COLS*WORD_SIZE-1:0] feed_data;
    logic [COLS-1:0]           feed_valid;
    logic                      done;

    modport master (
        output load_valid, load_data, start,
        input  load_ready, busy, feed_data, feed_valid, done
    );

    modport slave (
        input  load_valid, load_data, start,
        output load_ready, busy, feed_data, feed_valid, done
    );
endinterface
`default_nettype wire

// File: rtl/matmul_input_feeder.sv
`default_nettype none
// ============================================================================
// Module      : matmul_input_feeder
// Description : Buffers up to ROWS vectors of COLS words, then streams them
//               into the systolic array one lane per column, lane c skewed
//               by c cycles, each word held HOLD cycles.
//               Optional build macro FEEDER_ZERO_PAD_EN: every stream emits
//               exactly ROWS vectors, unloaded ones as zero words.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_input_feeder #(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int HOLD      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    matmul_input_feeder_if.slave feeder
);

    localparam int c_IDX_W  = $clog2(ROWS) + 1;
    localparam int c_ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_HOLD_W = $clog2(HOLD) + 1;
    localparam int c_DRN_W  = $clog2(COLS) + 1;
    localparam int c_PIPE_D = (COLS > 1) ? COLS - 1 : 1;
    localparam int c_LW     = COLS * WORD_SIZE;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_vec_count;
    logic [c_IDX_W-1:0]   w_vec_count_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [c_HOLD_W-1:0]  w_hold_nxt;
    logic [c_DRN_W-1:0]   r_drain;
    logic [c_DRN_W-1:0]   w_drain_nxt;

    // "Head" = what lane 0 shows next cycle; lanes c>0 replay it c cycles later.
    logic                 w_head_vld;
    logic [c_IDX_W-1:0]   w_head_idx;
    logic [WORD_SIZE-1:0] w_lane0_word;

    logic                 w_load_acc;
    logic                 w_start_ok;
    logic [c_IDX_W-1:0]   w_last_idx;

    logic                 r_load_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [COLS-1:0]      r_feed_valid;
    logic [c_LW-1:0]      r_feed_data;

    logic [c_PIPE_D-1:0]  r_pipe_vld;
    logic [c_IDX_W-1:0]   r_pipe_idx [c_PIPE_D];
    logic [c_LW-1:0]      r_buf      [ROWS];

    assign w_load_acc = feeder.load_valid & r_load_ready;

`ifdef FEEDER_ZERO_PAD_EN
    // Stream length is always ROWS; unloaded rows are masked to zero below.
    assign w_start_ok = 1'b1;
    assign w_last_idx = c_IDX_W'(ROWS - 1);
`else
    // Stream length is the number of loaded vectors, including a beat
    // accepted in the same cycle as start.
    assign w_start_ok = (r_vec_count != '0) || w_load_acc;
    assign w_last_idx = r_vec_count - c_IDX_W'(1);
`endif

    // State register and stream counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vec_count  <= '0;
            r_idx        <= '0;
            r_hold       <= '0;
            r_drain      <= '0;
            r_load_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vec_count  <= w_vec_count_nxt;
            r_idx        <= w_idx_nxt;
            r_hold       <= w_hold_nxt;
            r_drain      <= w_drain_nxt;
            r_load_ready <= (w_state_nxt == S_IDLE) && (w_vec_count_nxt < c_IDX_W'(ROWS));
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state logic and lane-0 head generation
    always_comb begin
        w_state_nxt     = r_state;
        w_vec_count_nxt = r_vec_count;
        w_idx_nxt       = r_idx;
        w_hold_nxt      = r_hold;
        w_drain_nxt     = r_drain;
        w_head_vld      = 1'b0;
        w_head_idx      = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_load_acc) begin
                    w_vec_count_nxt = r_vec_count + c_IDX_W'(1);
                end
                if (feeder.start && w_start_ok) begin
                    w_state_nxt = S_STREAM;
                    w_idx_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_head_vld  = 1'b1;
                    w_head_idx  = '0;
                end
            end
            S_STREAM: begin
                if (r_hold == c_HOLD_W'(HOLD - 1)) begin
                    if (r_idx == w_last_idx) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = '0;
                    end else begin
                        w_idx_nxt  = r_idx + c_IDX_W'(1);
                        w_hold_nxt = '0;
                        w_head_vld = 1'b1;
                        w_head_idx = r_idx + c_IDX_W'(1);
                    end
                end else begin
                    w_hold_nxt = r_hold + c_HOLD_W'(1);
                    w_head_vld = 1'b1;
                end
            end
            S_DRAIN: begin
                // Wait for the last lane to run out, plus one idle cycle.
                if (r_drain == c_DRN_W'(COLS - 1)) begin
                    w_state_nxt     = S_DONE;
                    w_vec_count_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain + c_DRN_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Lane-0 word; bypasses the buffer when the vector is being loaded in
    // the very cycle streaming starts.
    always_comb begin
        w_lane0_word = '0;
        if (w_head_vld && (w_head_idx < w_vec_count_nxt)) begin
            if (w_load_acc && (w_head_idx == r_vec_count)) begin
                w_lane0_word = feeder.load_data[WORD_SIZE-1:0];
            end else begin
                w_lane0_word = r_buf[w_head_idx[c_ADDR_W-1:0]][WORD_SIZE-1:0];
            end
        end
    end

    // Vector buffer; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            r_buf[r_vec_count[c_ADDR_W-1:0]] <= feeder.load_data;
        end
    end

    // Skew delay line and registered lane outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld   <= '0;
            r_feed_valid <= '0;
            r_feed_data  <= '0;
            for (int s = 0; s < c_PIPE_D; s++) begin
                r_pipe_idx[s] <= '0;
            end
        end else begin
            r_feed_valid[0]               <= w_head_vld;
            r_feed_data[WORD_SIZE-1:0]    <= w_lane0_word;
            r_pipe_vld[0]                 <= w_head_vld;
            r_pipe_idx[0]                 <= w_head_idx;
            for (int s = 1; s < COLS - 1; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_idx[s] <= r_pipe_idx[s-1];
            end
            for (int c = 1; c < COLS; c++) begin
                r_feed_valid[c] <= r_pipe_vld[c-1];
                if (r_pipe_vld[c-1] && (r_pipe_idx[c-1] < r_vec_count)) begin
                    r_feed_data[c*WORD_SIZE +: WORD_SIZE] <=
                        r_buf[r_pipe_idx[c-1][c_ADDR_W-1:0]][c*WORD_SIZE +: WORD_SIZE];
                end else begin
                    r_feed_data[c*WORD_SIZE +: WORD_SIZE] <= '0;
                end
            end
        end
    end

    assign feeder.load_ready = r_load_ready;
    assign feeder.busy       = r_busy;
    assign feeder.done       = r_done;
    assign feeder.feed_valid = r_feed_valid;
    assign feeder.feed_data  = r_feed_data;

endmodule
`default_nettype wire

// File: tb/tb_matmul_input_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_input_feeder
// Description : Self-checking bench for matmul_input_feeder (table of
//               stream scenarios plus hand-written reset/empty sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matmul_input_feeder;

    localparam int WORD_SIZE = 16;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int HOLD      = 2;
    localparam int LW        = COLS * WORD_SIZE;
`ifdef FEEDER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_input_feeder_if #(.WORD_SIZE(WORD_SIZE), .COLS(COLS)) bus ();

    matmul_input_feeder #(
        .WORD_SIZE(WORD_SIZE), .ROWS(ROWS), .COLS(COLS), .HOLD(HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .feeder(bus)
    );

    typedef struct packed {
        logic            ready;
        logic            busy;
        logic            done;
        logic [COLS-1:0] valid;
        logic [LW-1:0]   data;
    } exp_t;

    typedef struct {
        int n_beats;
        bit coincide;
        bit extra;
        int mid_start;
        int exp_done;
    } vec_t;

    exp_t          sb_q [$];
    logic [LW-1:0] mdl_buf [ROWS];
    int            mdl_cnt = 0;
    int            checks  = 0;
    int            errors  = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] word(input int scen, input int row);
        logic [LW-1:0] v = '0;
        for (int c = 0; c < COLS; c++) v[c*WORD_SIZE +: WORD_SIZE] = 16'(16*row + c + 256*scen);
        return v;
    endfunction

    // Expected outputs at offset o after the start edge (o=0 is t0).
    function automatic exp_t exp_at(input int o, input int nstr);
        exp_t e;
        int   k;
        e.ready = (o > HOLD*nstr + COLS);
        e.busy  = (o <= HOLD*nstr + COLS);
        e.done  = (o == HOLD*nstr + COLS);
        e.valid = '0;
        e.data  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (o >= c && (o - c) < HOLD*nstr) begin
                k = (o - c) / HOLD;
                e.valid[c] = 1'b1;
                if (k < mdl_cnt) e.data[c*WORD_SIZE +: WORD_SIZE] = mdl_buf[k][c*WORD_SIZE +: WORD_SIZE];
            end
        end
        return e;
    endfunction

    task automatic push_stream();
        int nstr;
        nstr = PAD ? ROWS : mdl_cnt;
        for (int o = 0; o <= HOLD*nstr + COLS + 1; o++) sb_q.push_back(exp_at(o, nstr));
    endtask

    task automatic load_beat(input logic [LW-1:0] d);
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = (mdl_cnt < ROWS);
        chk("load_ready", 96'(bus.load_ready), 96'(exp_rdy));
        bus.start      = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        if (exp_rdy) begin
            mdl_buf[mdl_cnt] = d;
            mdl_cnt++;
        end
    endtask

    task automatic kick(input bit with_beat, input logic [LW-1:0] d);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.load_valid = with_beat;
        bus.load_data  = d;
        if (with_beat) begin
            chk("load_ready_at_start", 96'(bus.load_ready), 96'(1'b1));
            mdl_buf[mdl_cnt] = d;
            mdl_cnt++;
        end
        push_stream();
    endtask

    task automatic run_stream(input int mid_start, input int abort_off,
                              output int done_off, output int n_done);
        exp_t e;
        int   off;
        done_off = -1;
        n_done   = 0;
        off      = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            bus.start      = (off == mid_start);
            bus.load_valid = 1'b0;
            e = sb_q.pop_front();
            chk($sformatf("stream_t0+%0d", off),
                96'({bus.load_ready, bus.busy, bus.done, bus.feed_valid, bus.feed_data}), 96'(e));
            if (bus.done === 1'b1) begin
                n_done++;
                done_off = off;
            end
            if (off == abort_off) begin
                rst = 1'b1;
                sb_q.delete();
            end
            off++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [4];
        int   nl;
        int   d_off;
        int   n_done;
        logic any_done;

        tbl[0] = '{n_beats: 4, coincide: 1'b0, extra: 1'b1, mid_start: -1, exp_done: 12};
        tbl[1] = '{n_beats: 2, coincide: 1'b0, extra: 1'b0, mid_start: -1, exp_done: (PAD ? 12 : 8)};
        tbl[2] = '{n_beats: 3, coincide: 1'b0, extra: 1'b0, mid_start: 3,  exp_done: (PAD ? 12 : 10)};
        tbl[3] = '{n_beats: 1, coincide: 1'b1, extra: 1'b0, mid_start: -1, exp_done: (PAD ? 12 : 6)};

        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 96'({bus.load_ready, bus.busy, bus.done, bus.feed_valid, bus.feed_data}),
            96'({1'b1, 1'b0, 1'b0, {COLS{1'b0}}, {LW{1'b0}}}));
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            nl = tbl[i].coincide ? tbl[i].n_beats - 1 : tbl[i].n_beats;
            for (int b = 0; b < nl; b++) load_beat(word(i, b));
            if (tbl[i].extra) load_beat({(LW/16){16'hDEAD}});
            kick(tbl[i].coincide, word(i, tbl[i].n_beats - 1));
            run_stream(tbl[i].mid_start, -1, d_off, n_done);
            chk($sformatf("done_time_s%0d", i), 96'(d_off), 96'(tbl[i].exp_done));
            chk($sformatf("done_count_s%0d", i), 96'(n_done), 96'(1));
            mdl_cnt = 0;
        end

        // Reset in the middle of a stream
        for (int b = 0; b < 4; b++) load_beat(word(8, b));
        kick(1'b0, '0);
        run_stream(-1, 5, d_off, n_done);
        @(negedge clk);
        chk("after_abort", 96'({bus.load_ready, bus.busy, bus.done, bus.feed_valid, bus.feed_data}),
            96'({1'b1, 1'b0, 1'b0, {COLS{1'b0}}, {LW{1'b0}}}));
        rst     = 1'b0;
        mdl_cnt = 0;
        any_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) any_done = 1'b1;
        end
        chk("quiet_after_abort", 96'(any_done), 96'(1'b0));

        // Reload and restream after the abort
        for (int b = 0; b < 2; b++) load_beat(word(9, b));
        kick(1'b0, '0);
        run_stream(-1, -1, d_off, n_done);
        chk("done_time_restream", 96'(d_off), 96'(PAD ? 12 : 8));
        chk("done_count_restream", 96'(n_done), 96'(1));
        mdl_cnt = 0;

        // Start with an empty buffer
        if (PAD) begin
            kick(1'b0, '0);
            run_stream(-1, -1, d_off, n_done);
            chk("done_time_empty", 96'(d_off), 96'(12));
        end else begin
            @(negedge clk);
            bus.start = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bus.start = 1'b0;
                chk($sformatf("empty_start_%0d", k),
                    96'({bus.load_ready, bus.busy, bus.done, bus.feed_valid}),
                    96'({1'b1, 1'b0, 1'b0, {COLS{1'b0}}}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
